// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter: FSM states,
// requester IDs and the starvation counter width.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_DMA  = 2'd2,
    REQ_DBG  = 2'd3
  } req_id_t;

  localparam int STARVE_W = 8;

endpackage

// File: rtl/dram_arb_starve_cnt.sv
// Saturating wait counter for one low-priority requester. starved is the
// registered "waited STARVE_MAX cycles" flag; sat_next predicts it one cycle early.
module dram_arb_starve_cnt
  import dram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  input  logic hold,
  output logic starved,
  output logic sat_next
);

  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt;
  logic [STARVE_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (!req || gnt) begin
      cnt_nxt = '0;
    end else if (!hold && (cnt != CNT_MAX)) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign starved  = (cnt == CNT_MAX);
  assign sat_next = (cnt_nxt == CNT_MAX);

endmodule

// File: rtl/dram_arbiter.sv
// Data-RAM port arbiter: CPU fixed priority, DMA/debug round-robin, DMA burst lock.
// Define DRAM_ARB_STARVE_EN to build in the starvation guard (counters + FORCE state).
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int DWIDTH     = 12,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              dma_req,
  input  logic              dbg_req,
  input  logic              cpu_we,
  input  logic              dma_we,
  input  logic              dbg_we,
  input  logic [3:0]        cpu_be,
  input  logic [3:0]        dma_be,
  input  logic [3:0]        dbg_be,
  input  logic [DWIDTH-1:0] cpu_adr,
  input  logic [DWIDTH-1:0] dma_adr,
  input  logic [DWIDTH-1:0] dbg_adr,
  input  logic [31:0]       cpu_wdata,
  input  logic [31:0]       dma_wdata,
  input  logic [31:0]       dbg_wdata,
  input  logic              dma_lock,
  output logic              cpu_gnt,
  output logic              dma_gnt,
  output logic              dbg_gnt,
  output logic              cpu_rvalid,
  output logic              dma_rvalid,
  output logic              dbg_rvalid,
  output logic [31:0]       rdata,
  output logic              cpu_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [DWIDTH-1:0] ram_adr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("dram_arbiter: STARVE_MAX must be in 1..255");
  end

  arb_state_t state;
  arb_state_t state_nxt;
  logic       rr;
  req_id_t    rd_id_p1;
  logic       arb_cpu, arb_dma, arb_dbg;
  logic       dma_starved, dbg_starved;
  logic       force_dma, force_dbg, forced;

`ifdef DRAM_ARB_STARVE_EN
  logic dma_sat_next, dbg_sat_next;

  // DMA waiting time is frozen while it owns the port in a burst
  dram_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_dma_cnt (
    .clk(clk), .rst(rst), .req(dma_req), .gnt(dma_gnt), .hold(state == ST_LOCK),
    .starved(dma_starved), .sat_next(dma_sat_next)
  );

  dram_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_dbg_cnt (
    .clk(clk), .rst(rst), .req(dbg_req), .gnt(dbg_gnt), .hold(1'b0),
    .starved(dbg_starved), .sat_next(dbg_sat_next)
  );
`else
  assign dma_starved = 1'b0;
  assign dbg_starved = 1'b0;
`endif

  assign arb_cpu   = cpu_req;
  assign arb_dma   = ~cpu_req & dma_req & (~rr | ~dbg_req);
  assign arb_dbg   = ~cpu_req & dbg_req & ~arb_dma;
  assign force_dma = dma_starved & dma_req;
  assign force_dbg = dbg_starved & dbg_req & ~force_dma;
  assign forced    = (state == ST_FORCE) & (force_dma | force_dbg);

  // Grant decode; a lock exit or an empty FORCE cycle falls through to normal arbitration
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (state == ST_LOCK && dma_req && dma_lock) begin
      dma_gnt = 1'b1;
    end else if (forced) begin
      dma_gnt = force_dma;
      dbg_gnt = force_dbg;
    end else begin
      cpu_gnt = arb_cpu;
      dma_gnt = arb_dma;
      dbg_gnt = arb_dbg;
    end
    if (rst) begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end
  end

  always_comb begin
    state_nxt = ST_ARB;
    if (dma_gnt && dma_lock && !forced) begin
      state_nxt = ST_LOCK;
    end
`ifdef DRAM_ARB_STARVE_EN
    if (dma_sat_next || dbg_sat_next) begin
      state_nxt = ST_FORCE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ARB;
      rr       <= 1'b0;
      rd_id_p1 <= REQ_NONE;
    end else begin
      state <= state_nxt;
      if (dma_gnt || dbg_gnt) begin
        rr <= ~rr;
      end
      if (cpu_gnt && !cpu_we) begin
        rd_id_p1 <= REQ_CPU;
      end else if (dma_gnt && !dma_we) begin
        rd_id_p1 <= REQ_DMA;
      end else if (dbg_gnt && !dbg_we) begin
        rd_id_p1 <= REQ_DBG;
      end else begin
        rd_id_p1 <= REQ_NONE;
      end
    end
  end

  // p1: read return, one cycle after the granted read
  assign cpu_rvalid = (rd_id_p1 == REQ_CPU);
  assign dma_rvalid = (rd_id_p1 == REQ_DMA);
  assign dbg_rvalid = (rd_id_p1 == REQ_DBG);
  assign rdata      = ram_rdata;
  assign cpu_stall  = cpu_req & ~cpu_gnt & ~rst;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_adr   = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_en = 1'b1; ram_we = cpu_we; ram_be = cpu_be; ram_adr = cpu_adr; ram_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      ram_en = 1'b1; ram_we = dma_we; ram_be = dma_be; ram_adr = dma_adr; ram_wdata = dma_wdata;
    end else if (dbg_gnt) begin
      ram_en = 1'b1; ram_we = dbg_we; ram_be = dbg_be; ram_adr = dbg_adr; ram_wdata = dbg_wdata;
    end
  end

endmodule
